// File: rtl/sbus20_pkg.sv
// Shared types and helpers for the S-bus request sequencer.
//   state_e       : sequencer states
//   wd_t / mask_t : word index within a quad, per-word request mask
//   first_wd_mask : request mask from the quad flag and the starting word
package sbus20_pkg;

  localparam int unsigned ADR_W           = 22;
  localparam int unsigned WD_W            = 2;
  localparam int unsigned MASK_W          = 4;
  localparam int unsigned NXM_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RD_XFER,
    ST_WR_XFER,
    ST_NXM_FILL
  } state_e;

  typedef logic [WD_W-1:0]   wd_t;
  typedef logic [MASK_W-1:0] mask_t;

  // Quad requests every word; a single request only the starting word.
  function automatic mask_t first_wd_mask(input logic quad, input wd_t wd);
    mask_t m;
    if (quad) m = 4'b1111;
    else      m = MASK_W'(4'b0001 << wd);
    return m;
  endfunction

endpackage

// File: rtl/sbus_nxm_timer.sv
// Non-existent-memory watchdog: counts enabled cycles, clears on clr_i or
// whenever disabled, and flags the cycle in which the count reaches
// NXM_TIMEOUT.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart the count (ackn or data valid seen)
//   en_i         : count this cycle
//   expire_c_o   : combinational; this cycle is the NXM_TIMEOUT-th one
module sbus_nxm_timer #(
  parameter int unsigned NXM_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = $clog2(NXM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear in the expiry cycle suppresses the expiry.
  assign expire_c_o = en_i && !clr_i && (cnt_q == CNT_W'(NXM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || expire_c_o) cnt_d = '0;
    else                              cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sbus_seq20.sv
// S-bus request sequencer: accepts one core read/write request, holds the
// S-bus start/request lines until ackn, then sequences single or quad word
// transfers in wrap-around order, with NXM timeout and error strobes.
// Optional feature macro: SBUS_ADR_PARITY_EN (address parity out, parity
// error abort). Without it sbus_adr_par_h and adr_par_err_h stay 0.
//   core_*_rq_h, rq_*_h        : request from the MBox core
//   sbus_start/rd/wr/adr/mask  : S-bus request lines (registered)
//   sbus_ackn/data_valid/error : memory responses
//   data_val/data_wd/nxm_data  : per-word delivery strobe and word number
//   core_busy, nxm_err, mem_err, adr_par_err, done : status to MBox
module sbus_seq20
  import sbus20_pkg::*;
#(
  parameter int unsigned NXM_TIMEOUT = NXM_TIMEOUT_DEF
) (
  input  logic             clk_sbus_h,
  input  logic             mr_reset_sbus_h,
  input  logic             core_rd_rq_h,
  input  logic             core_wr_rq_h,
  input  logic [ADR_W-1:0] rq_adr_h,
  input  logic             rq_quad_h,
  input  logic [WD_W-1:0]  rq_first_wd_h,
  output logic             rq_ack_h,
  output logic             sbus_start_h,
  output logic             sbus_rd_rq_h,
  output logic             sbus_wr_rq_h,
  output logic [ADR_W-1:0] sbus_adr_h,
  output logic [MASK_W-1:0] sbus_rq_mask_h,
  output logic             sbus_adr_par_h,
  input  logic             sbus_ackn_h,
  input  logic             sbus_data_valid_h,
  input  logic             sbus_error_h,
  input  logic             sbus_adr_par_err_h,
  output logic             sbus_wr_dv_h,
  output logic             data_val_h,
  output logic [WD_W-1:0]  data_wd_h,
  output logic             nxm_data_h,
  output logic             core_busy_h,
  output logic             nxm_err_h,
  output logic             mem_err_h,
  output logic             adr_par_err_h,
  output logic             done_h
);

`ifdef SBUS_ADR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             xfer_rd_q, xfer_rd_d;
  wd_t              word_q, word_d;
  wd_t              left_q, left_d;      // words remaining after the current one
  logic [ADR_W-1:0] adr_q, adr_d;
  mask_t            mask_q, mask_d;
  logic             par_q, par_d;
  logic             start_q, start_d;
  logic             rd_rq_q, rd_rq_d;
  logic             wr_rq_q, wr_rq_d;
  logic             busy_q, busy_d;
  logic             rq_ack_q, rq_ack_d;
  logic             wr_dv_q, wr_dv_d;
  logic             data_val_q, data_val_d;
  wd_t              data_wd_q, data_wd_d;
  logic             nxm_data_q, nxm_data_d;
  logic             nxm_err_q, nxm_err_d;
  logic             mem_err_q, mem_err_d;
  logic             adr_par_err_q, adr_par_err_d;
  logic             done_q, done_d;

  logic tmr_en, tmr_clr, tmr_expire, par_abort, emit;

  assign tmr_en    = (state_q == ST_START) || (state_q == ST_RD_XFER);
  assign tmr_clr   = sbus_ackn_h || sbus_data_valid_h;
  assign par_abort = PAR_EN && sbus_adr_par_err_h;

  sbus_nxm_timer #(
    .NXM_TIMEOUT(NXM_TIMEOUT)
  ) u_nxm_timer (
    .clk_i      (clk_sbus_h),
    .rst_i      (mr_reset_sbus_h),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .expire_c_o (tmr_expire)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    xfer_rd_d     = xfer_rd_q;
    word_d        = word_q;
    left_d        = left_q;
    adr_d         = adr_q;
    mask_d        = mask_q;
    par_d         = par_q;
    start_d       = start_q;
    rd_rq_d       = rd_rq_q;
    wr_rq_d       = wr_rq_q;
    busy_d        = busy_q;
    rq_ack_d      = 1'b0;
    wr_dv_d       = 1'b0;
    data_val_d    = 1'b0;
    data_wd_d     = '0;
    nxm_data_d    = 1'b0;
    nxm_err_d     = 1'b0;
    mem_err_d     = 1'b0;
    adr_par_err_d = 1'b0;
    done_d        = 1'b0;
    emit          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // busy_q still high here means the done cycle: enforce one idle cycle.
        if (!busy_q && (core_rd_rq_h || core_wr_rq_h)) begin
          rq_ack_d  = 1'b1;
          busy_d    = 1'b1;
          start_d   = 1'b1;
          rd_rq_d   = core_rd_rq_h;
          wr_rq_d   = !core_rd_rq_h;
          xfer_rd_d = core_rd_rq_h;
          adr_d     = rq_adr_h;
          mask_d    = first_wd_mask(rq_quad_h, rq_first_wd_h);
          par_d     = PAR_EN && !(^rq_adr_h);
          word_d    = rq_first_wd_h;
          left_d    = rq_quad_h ? 2'd3 : 2'd0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (par_abort) begin
          adr_par_err_d = 1'b1;
        end else if (sbus_ackn_h) begin
          start_d = 1'b0;
          rd_rq_d = 1'b0;
          wr_rq_d = 1'b0;
          state_d = xfer_rd_q ? ST_RD_XFER : ST_WR_XFER;
        end else if (tmr_expire) begin
          nxm_err_d = 1'b1;
          start_d   = 1'b0;
          rd_rq_d   = 1'b0;
          wr_rq_d   = 1'b0;
          if (xfer_rd_q) begin
            state_d = ST_NXM_FILL;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_XFER: begin
        if (par_abort) begin
          adr_par_err_d = 1'b1;
        end else if (sbus_data_valid_h) begin
          emit      = 1'b1;
          mem_err_d = sbus_error_h;
        end else if (tmr_expire) begin
          nxm_err_d = 1'b1;
          state_d   = ST_NXM_FILL;
        end
      end
      ST_WR_XFER: begin
        emit    = 1'b1;
        wr_dv_d = 1'b1;
      end
      ST_NXM_FILL: begin
        emit       = 1'b1;
        nxm_data_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Parity abort drops everything without done.
    if (adr_par_err_d) begin
      start_d = 1'b0;
      rd_rq_d = 1'b0;
      wr_rq_d = 1'b0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end

    // Deliver the current word and advance in wrap-around order.
    if (emit) begin
      data_val_d = 1'b1;
      data_wd_d  = word_q;
      word_d     = word_q + 2'd1;
      left_d     = left_q - 2'd1;
      if (left_q == 2'd0) begin
        left_d  = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_sbus_h) begin
    if (mr_reset_sbus_h) begin
      state_q       <= ST_IDLE;
      xfer_rd_q     <= 1'b0;
      word_q        <= '0;
      left_q        <= '0;
      adr_q         <= '0;
      mask_q        <= '0;
      par_q         <= 1'b0;
      start_q       <= 1'b0;
      rd_rq_q       <= 1'b0;
      wr_rq_q       <= 1'b0;
      busy_q        <= 1'b0;
      rq_ack_q      <= 1'b0;
      wr_dv_q       <= 1'b0;
      data_val_q    <= 1'b0;
      data_wd_q     <= '0;
      nxm_data_q    <= 1'b0;
      nxm_err_q     <= 1'b0;
      mem_err_q     <= 1'b0;
      adr_par_err_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      xfer_rd_q     <= xfer_rd_d;
      word_q        <= word_d;
      left_q        <= left_d;
      adr_q         <= adr_d;
      mask_q        <= mask_d;
      par_q         <= par_d;
      start_q       <= start_d;
      rd_rq_q       <= rd_rq_d;
      wr_rq_q       <= wr_rq_d;
      busy_q        <= busy_d;
      rq_ack_q      <= rq_ack_d;
      wr_dv_q       <= wr_dv_d;
      data_val_q    <= data_val_d;
      data_wd_q     <= data_wd_d;
      nxm_data_q    <= nxm_data_d;
      nxm_err_q     <= nxm_err_d;
      mem_err_q     <= mem_err_d;
      adr_par_err_q <= adr_par_err_d;
      done_q        <= done_d;
    end
  end

  assign rq_ack_h       = rq_ack_q;
  assign sbus_start_h   = start_q;
  assign sbus_rd_rq_h   = rd_rq_q;
  assign sbus_wr_rq_h   = wr_rq_q;
  assign sbus_adr_h     = adr_q;
  assign sbus_rq_mask_h = mask_q;
  assign sbus_adr_par_h = par_q;
  assign sbus_wr_dv_h   = wr_dv_q;
  assign data_val_h     = data_val_q;
  assign data_wd_h      = data_wd_q;
  assign nxm_data_h     = nxm_data_q;
  assign core_busy_h    = busy_q;
  assign nxm_err_h      = nxm_err_q;
  assign mem_err_h      = mem_err_q;
  assign adr_par_err_h  = adr_par_err_q;
  assign done_h         = done_q;

endmodule

// File: tb/tb_sbus_seq20.sv
// Directed bench for sbus_seq20 (NXM_TIMEOUT = 8): a per-cycle vector table
// for a quad read, plus short sequences for write, NXM, reset and parity.
module tb_sbus_seq20;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rd_rq_h, core_wr_rq_h;
  logic [21:0] rq_adr_h;
  logic        rq_quad_h;
  logic [1:0]  rq_first_wd_h;
  logic        rq_ack_h, sbus_start_h, sbus_rd_rq_h, sbus_wr_rq_h;
  logic [21:0] sbus_adr_h;
  logic [3:0]  sbus_rq_mask_h;
  logic        sbus_adr_par_h;
  logic        sbus_ackn_h, sbus_data_valid_h, sbus_error_h, sbus_adr_par_err_h;
  logic        sbus_wr_dv_h, data_val_h;
  logic [1:0]  data_wd_h;
  logic        nxm_data_h, core_busy_h, nxm_err_h, mem_err_h, adr_par_err_h, done_h;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sbus_seq20 #(.NXM_TIMEOUT(TO)) dut (
    .clk_sbus_h        (clk),
    .mr_reset_sbus_h   (rst),
    .core_rd_rq_h      (core_rd_rq_h),
    .core_wr_rq_h      (core_wr_rq_h),
    .rq_adr_h          (rq_adr_h),
    .rq_quad_h         (rq_quad_h),
    .rq_first_wd_h     (rq_first_wd_h),
    .rq_ack_h          (rq_ack_h),
    .sbus_start_h      (sbus_start_h),
    .sbus_rd_rq_h      (sbus_rd_rq_h),
    .sbus_wr_rq_h      (sbus_wr_rq_h),
    .sbus_adr_h        (sbus_adr_h),
    .sbus_rq_mask_h    (sbus_rq_mask_h),
    .sbus_adr_par_h    (sbus_adr_par_h),
    .sbus_ackn_h       (sbus_ackn_h),
    .sbus_data_valid_h (sbus_data_valid_h),
    .sbus_error_h      (sbus_error_h),
    .sbus_adr_par_err_h(sbus_adr_par_err_h),
    .sbus_wr_dv_h      (sbus_wr_dv_h),
    .data_val_h        (data_val_h),
    .data_wd_h         (data_wd_h),
    .nxm_data_h        (nxm_data_h),
    .core_busy_h       (core_busy_h),
    .nxm_err_h         (nxm_err_h),
    .mem_err_h         (mem_err_h),
    .adr_par_err_h     (adr_par_err_h),
    .done_h            (done_h)
  );

  // vin : {rd, wr, quad, first_wd[1:0], ackn, dv, err}
  // vexp: {ack, start, rd_rq, wr_rq, busy, dval, wd[1:0], done, mem_err, nxm_err, nxm_data, mask[3:0]}
  typedef struct packed {
    logic [7:0]  vin;
    logic [15:0] vexp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    core_rd_rq_h = 1'b0; core_wr_rq_h = 1'b0; rq_quad_h = 1'b0; rq_first_wd_h = 2'd0;
    sbus_ackn_h = 1'b0; sbus_data_valid_h = 1'b0; sbus_error_h = 1'b0; sbus_adr_par_err_h = 1'b0;
  endtask

  function automatic logic [15:0] row_out();
    return {rq_ack_h, sbus_start_h, sbus_rd_rq_h, sbus_wr_rq_h, core_busy_h, data_val_h,
            data_wd_h, done_h, mem_err_h, nxm_err_h, nxm_data_h, sbus_rq_mask_h};
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({rq_ack_h, sbus_start_h, sbus_rd_rq_h, sbus_wr_rq_h, sbus_adr_h, sbus_rq_mask_h,
                sbus_adr_par_h, sbus_wr_dv_h, data_val_h, data_wd_h, nxm_data_h, core_busy_h,
                nxm_err_h, mem_err_h, adr_par_err_h, done_h});
  endfunction

  initial begin
    int k;
    // Quad read from word 2, ackn in the 3rd start cycle, error on word 3,
    // requests while busy (and in the done cycle) ignored.
    tbl[0]  = '{vin: 8'b1011_0000, vexp: 16'b1110_1000_0000_1111};
    tbl[1]  = '{vin: 8'b0100_0000, vexp: 16'b0110_1000_0000_1111};
    tbl[2]  = '{vin: 8'b0000_0000, vexp: 16'b0110_1000_0000_1111};
    tbl[3]  = '{vin: 8'b0000_0100, vexp: 16'b0000_1000_0000_1111};
    tbl[4]  = '{vin: 8'b0000_0010, vexp: 16'b0000_1110_0000_1111};
    tbl[5]  = '{vin: 8'b0000_0000, vexp: 16'b0000_1000_0000_1111};
    tbl[6]  = '{vin: 8'b0000_0011, vexp: 16'b0000_1111_0100_1111};
    tbl[7]  = '{vin: 8'b0000_0010, vexp: 16'b0000_1100_0000_1111};
    tbl[8]  = '{vin: 8'b0000_0010, vexp: 16'b0000_1101_1000_1111};
    tbl[9]  = '{vin: 8'b1000_0000, vexp: 16'b0000_0000_0000_1111};
    tbl[10] = '{vin: 8'b0000_0000, vexp: 16'b0000_0000_0000_1111};

    rst = 1'b1;
    rq_adr_h = 22'h2ABCD;
    clr_in();
    cyc();
    cyc();
    chk("reset_outputs", all_out(), 64'd0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 11; i++) begin
      {core_rd_rq_h, core_wr_rq_h, rq_quad_h, rq_first_wd_h,
       sbus_ackn_h, sbus_data_valid_h, sbus_error_h} = tbl[i].vin;
      cyc();
      chk($sformatf("quad_rd_row%0d", i), 64'(row_out()), 64'(tbl[i].vexp));
    end
    chk("latched_adr", 64'(sbus_adr_h), 64'(22'h2ABCD));

    // Single write to word 1.
    clr_in();
    rq_adr_h = 22'h00F00;
    core_wr_rq_h = 1'b1; rq_first_wd_h = 2'd1;
    cyc();
    chk("wr_mask", 64'(sbus_rq_mask_h), 64'(4'b0010));
    chk("wr_rq_type", 64'({rq_ack_h, sbus_start_h, sbus_rd_rq_h, sbus_wr_rq_h}), 64'(4'b1101));
    clr_in();
    sbus_ackn_h = 1'b1;
    cyc();
    chk("wr_ackn", 64'({sbus_start_h, sbus_wr_dv_h, core_busy_h}), 64'(3'b001));
    sbus_ackn_h = 1'b0;
    cyc();
    chk("wr_word", 64'({sbus_wr_dv_h, data_val_h, data_wd_h, done_h}), 64'(5'b11011));
    cyc();
    chk("wr_end", 64'({core_busy_h, sbus_wr_dv_h, data_val_h, done_h}), 64'(4'b0000));

    // Read with no ackn: NXM after TO cycles, then 4 filler words.
    core_rd_rq_h = 1'b1; rq_quad_h = 1'b1; rq_first_wd_h = 2'd0;
    cyc();
    clr_in();
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (nxm_err_h) begin
        k = c;
        break;
      end
    end
    chk("nxm_latency", 64'(k), 64'(TO));
    chk("nxm_cycle", 64'({sbus_start_h, data_val_h, done_h, core_busy_h}), 64'(4'b0001));
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = 2'(i);
      cyc();
      chk($sformatf("nxm_fill%0d", i), 64'({data_val_h, nxm_data_h, data_wd_h, done_h, nxm_err_h}),
          64'({1'b1, 1'b1, w, (i == 3), 1'b0}));
    end
    cyc();
    chk("nxm_end", 64'({core_busy_h, data_val_h}), 64'(2'b00));

    // Both requests: read wins. Then reset in RD_XFER with data valid.
    core_rd_rq_h = 1'b1; core_wr_rq_h = 1'b1; rq_quad_h = 1'b0; rq_first_wd_h = 2'd3;
    cyc();
    chk("both_rq", 64'({rq_ack_h, sbus_rd_rq_h, sbus_wr_rq_h, sbus_rq_mask_h}), 64'(7'b110_1000));
    clr_in();
    sbus_ackn_h = 1'b1;
    cyc();
    sbus_ackn_h = 1'b0; sbus_data_valid_h = 1'b1; rst = 1'b1;
    cyc();
    chk("mid_reset", all_out(), 64'd0);
    rst = 1'b0; sbus_data_valid_h = 1'b0;
    cyc();
    chk("post_reset", all_out(), 64'd0);

    // Address parity.
    rq_adr_h = 22'h000001;
    core_rd_rq_h = 1'b1;
    cyc();
    chk("adr_par", 64'(sbus_adr_par_h), 64'd0);
    clr_in();
    sbus_adr_par_err_h = 1'b1;
    cyc();
`ifdef SBUS_ADR_PARITY_EN
    chk("par_abort", 64'({adr_par_err_h, sbus_start_h, core_busy_h, done_h}), 64'(4'b1000));
    sbus_adr_par_err_h = 1'b0;
    cyc();
    chk("par_after", 64'({adr_par_err_h, core_busy_h, done_h}), 64'(3'b000));
`else
    chk("par_ignored", 64'({adr_par_err_h, sbus_start_h, core_busy_h, done_h}), 64'(4'b0110));
    sbus_adr_par_err_h = 1'b0; sbus_ackn_h = 1'b1;
    cyc();
    sbus_ackn_h = 1'b0; sbus_data_valid_h = 1'b1;
    cyc();
    chk("par_ign_done", 64'({data_val_h, data_wd_h, done_h, adr_par_err_h}), 64'(5'b10010));
    sbus_data_valid_h = 1'b0;
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
